// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size codes, FSM states and address helpers for the data-memory responder
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: return {lo[1], 1'b0};
      SIZE_WORD: return 2'b00;
      default:   return lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-enable generation, store lane placement and load extraction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_shift;

  assign byte_shift = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o     = 4'b0000;
    wlanes_o = wdata_i;
    rdata_o  = '0;
    case (size_i)
      SIZE_BYTE: begin
        be_o     = 4'b0001 << addr_lo_i;
        wlanes_o = {4{wdata_i[7:0]}};
        rdata_o  = {24'h0, byte_shift[7:0]};
      end
      SIZE_HALF: begin
        be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wlanes_o = {2{wdata_i[15:0]}};
        rdata_o  = {16'h0, (addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0])};
      end
      SIZE_WORD: begin
        be_o     = 4'b1111;
        rdata_o  = rword_i;
      end
      default: begin
        be_o     = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data RAM responder; DMEM_ALIGN_CHECK_EN rejects misaligned half/word
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        data_mem_re_in,
  input  logic        data_mem_we_in,
  input  logic [1:0]  data_mem_size_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        err_out
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  we_q, err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  req, req_err, enter_done;
  logic [ADDR_WIDTH-1:0] req_addr, acc_addr;
  logic [1:0]            acc_size;
  logic [31:0]           acc_wdata, wlanes, ld_data;
  logic                  acc_we, acc_err;
  logic [3:0]            be;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr_in[31:ADDR_WIDTH];
  assign req = data_mem_re_in | data_mem_we_in;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_addr = addr_in[ADDR_WIDTH-1:0];
  assign req_err  = (data_mem_re_in & data_mem_we_in) | (data_mem_size_in == SIZE_RSVD) |
                    misaligned(data_mem_size_in, addr_in[1:0]);
`else
  assign req_addr = {addr_in[ADDR_WIDTH-1:2], force_align(data_mem_size_in, addr_in[1:0])};
  assign req_err  = (data_mem_re_in & data_mem_we_in) | (data_mem_size_in == SIZE_RSVD);
`endif

  // With no wait states the access completes on the accepting edge, so IDLE uses the live request.
  assign acc_addr  = (state_q == IDLE) ? req_addr         : addr_q;
  assign acc_size  = (state_q == IDLE) ? data_mem_size_in : size_q;
  assign acc_wdata = (state_q == IDLE) ? wdata_in         : wdata_q;
  assign acc_we    = (state_q == IDLE) ? data_mem_we_in   : we_q;
  assign acc_err   = (state_q == IDLE) ? req_err          : err_q;

  dmem_lane_align u_align (
    .addr_lo_i (acc_addr[1:0]),
    .size_i    (acc_size),
    .wdata_i   (acc_wdata),
    .rword_i   (mem[acc_addr[ADDR_WIDTH-1:2]]),
    .be_o      (be),
    .wlanes_o  (wlanes),
    .rdata_o   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_out = 1'b1;
          cnt_d     = '0;
          state_d   = (WAIT_CYCLES == 0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (cnt_q == WAIT_LAST) state_d = DONE;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_in) stall_out = 1'b0;
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE) && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_done && (acc_err || !acc_we)) rdata_q <= acc_err ? 32'h0 : ld_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if ((state_q == IDLE) && req) begin
      addr_q  <= req_addr;
      size_q  <= data_mem_size_in;
      wdata_q <= wdata_in;
      we_q    <= data_mem_we_in;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enter_done && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[acc_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign rdata_out = rdata_q;
  assign done_out  = (state_q == DONE);
  assign err_out   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_s [2];
  logic        we_s [2];
  logic [1:0]  sz_s [2];
  logic [31:0] ad_s [2];
  logic [31:0] wd_s [2];
  logic [31:0] rd_s [2];
  logic        st_s [2];
  logic        dn_s [2];
  logic        er_s [2];

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] sb_q [$];   // {check_rdata, err, rdata}

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_w2 (
    .clk_in(clk), .rst_in(rst), .data_mem_re_in(re_s[0]), .data_mem_we_in(we_s[0]),
    .data_mem_size_in(sz_s[0]), .addr_in(ad_s[0]), .wdata_in(wd_s[0]),
    .rdata_out(rd_s[0]), .stall_out(st_s[0]), .done_out(dn_s[0]), .err_out(er_s[0])
  );

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_w0 (
    .clk_in(clk), .rst_in(rst), .data_mem_re_in(re_s[1]), .data_mem_we_in(we_s[1]),
    .data_mem_size_in(sz_s[1]), .addr_in(ad_s[1]), .wdata_in(wd_s[1]),
    .rdata_out(rd_s[1]), .stall_out(st_s[1]), .done_out(dn_s[1]), .err_out(er_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input int d, input logic re, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic chk,
                     input logic [31:0] exp_rd, input logic exp_er);
    int          stalls;
    bit          got;
    logic [33:0] e;
    @(negedge clk);
    re_s[d] = re; we_s[d] = we; sz_s[d] = sz; ad_s[d] = a; wd_s[d] = wd;
    sb_q.push_back({chk, exp_er, exp_rd});
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (dn_s[d]) begin
        got = 1'b1;
        re_s[d] = 1'b0; we_s[d] = 1'b0;
        e = sb_q.pop_front();
        if (e[33]) check("rdata", rd_s[d], e[31:0]);
        check("err", 32'(er_s[d]), 32'(e[32]));
        check("stall_len", 32'(stalls), (d == 0) ? 32'd3 : 32'd1);
        check("stall_in_done", 32'(st_s[d]), 32'd0);
      end else begin
        if (st_s[d]) stalls++;
        @(negedge clk);
      end
    end
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      re_s[d] = 1'b0; we_s[d] = 1'b0;
      void'(sb_q.pop_back());
    end
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    acc(d, 1'b0, 1'b1, sz, a, wd, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic ld(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] exp);
    acc(d, 1'b1, 1'b0, sz, a, 32'h0, 1'b1, exp, 1'b0);
  endtask

  logic [31:0] b2b_addr [6] = '{32'h8, 32'hC, 32'hC, 32'h8, 32'h8, 32'hC};
  logic [33:0] e;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      re_s[d] = 1'b0; we_s[d] = 1'b0; sz_s[d] = SIZE_WORD; ad_s[d] = '0; wd_s[d] = '0;
    end
    re_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(st_s[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin
      check("rst_done", 32'(dn_s[d]), 32'd0);
      check("rst_err", 32'(er_s[d]), 32'd0);
      check("rst_rdata", rd_s[d], 32'd0);
    end
    re_s[0] = 1'b0;
    rst = 1'b0;

    st(0, SIZE_WORD, 32'h10, 32'hDEADBEEF);
    ld(0, SIZE_WORD, 32'h10, 32'hDEADBEEF);
    ld(0, SIZE_WORD, 32'h1010, 32'hDEADBEEF);
    ld(0, SIZE_WORD, 32'hFFFF_F010, 32'hDEADBEEF);

    st(0, SIZE_WORD, 32'h20, 32'h11223344);
    st(0, SIZE_BYTE, 32'h21, 32'hFFFF_FFAA);
    ld(0, SIZE_WORD, 32'h20, 32'h1122AA44);
    ld(0, SIZE_BYTE, 32'h21, 32'h000000AA);
    ld(0, SIZE_BYTE, 32'h23, 32'h00000011);
    ld(0, SIZE_HALF, 32'h22, 32'h00001122);

    st(0, SIZE_WORD, 32'h30, 32'h12345678);
    st(0, SIZE_HALF, 32'h32, 32'h0000BEEF);
    ld(0, SIZE_HALF, 32'h32, 32'h0000BEEF);
    ld(0, SIZE_WORD, 32'h30, 32'hBEEF5678);
`ifdef DMEM_ALIGN_CHECK_EN
    acc(0, 1'b0, 1'b1, SIZE_HALF, 32'h31, 32'h0000CAFE, 1'b0, 32'h0, 1'b1);
    ld(0, SIZE_WORD, 32'h30, 32'hBEEF5678);
`else
    acc(0, 1'b0, 1'b1, SIZE_HALF, 32'h31, 32'h0000CAFE, 1'b0, 32'h0, 1'b0);
    ld(0, SIZE_WORD, 32'h30, 32'hBEEFCAFE);
`endif

    st(0, SIZE_WORD, 32'h40, 32'h0BADF00D);
    acc(0, 1'b1, 1'b1, SIZE_WORD, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
    ld(0, SIZE_WORD, 32'h40, 32'h0BADF00D);
    acc(0, 1'b0, 1'b1, SIZE_RSVD, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
    ld(0, SIZE_WORD, 32'h40, 32'h0BADF00D);
    acc(0, 1'b1, 1'b0, SIZE_RSVD, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1);

    st(0, SIZE_WORD, 32'h50, 32'h77777777);
    @(negedge clk);
    we_s[0] = 1'b1; sz_s[0] = SIZE_WORD; ad_s[0] = 32'h50; wd_s[0] = 32'h55;
    #1 check("abort_stall_T", 32'(st_s[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_stall_rst", 32'(st_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0; we_s[0] = 1'b0;
    #1 check("abort_stall_after", 32'(st_s[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("abort_no_done", 32'(dn_s[0]), 32'd0);
      check("abort_no_err", 32'(er_s[0]), 32'd0);
      @(negedge clk);
      #1;
    end
    ld(0, SIZE_WORD, 32'h50, 32'h77777777);

    st(1, SIZE_WORD, 32'h8, 32'h00001234);
    st(1, SIZE_WORD, 32'hC, 32'h00005678);
    ld(1, SIZE_WORD, 32'h8, 32'h00001234);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      re_s[1] = 1'b1; sz_s[1] = SIZE_WORD; ad_s[1] = b2b_addr[i];
      if (i % 2 == 0)
        sb_q.push_back({1'b1, 1'b0, (b2b_addr[i] == 32'h8) ? 32'h00001234 : 32'h00005678});
      #1;
      check("b2b_stall", 32'(st_s[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("b2b_done", 32'(dn_s[1]), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (dn_s[1] && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("b2b_rdata", rd_s[1], e[31:0]);
      end
    end
    @(negedge clk);
    re_s[1] = 1'b0;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
